fp_trace_packer: RTL and testbench

- Passive monitor on the fp_unit execute interface.
- Pairs each issued operation with its completion and packs the pair into one 156-bit test-vector record, using the same layout the FPU vector benches consume from fpu.dat.
- Buffers records in a small FIFO and streams them out over valid/ready to a trace sink (memory writer or host dump), so directed or random hardware runs can be replayed as golden vectors.

---
 rtl/fp_trace_packer.sv | 171 +++++++++++++++++
 tb/tb_fp_trace_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_trace_packer.sv
`default_nettype none
// ============================================================================
// fp_trace_packer : pairs FPU issue/completion into 156-bit vector records
//                   and streams them out of a small FWFT FIFO.   Rev 1.0
// ============================================================================
module fp_trace_packer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [31:0]       req_data1,
   input  logic [31:0]       req_data2,
   input  logic [31:0]       req_data3,
   input  logic [2:0]        req_rm,
   input  logic [1:0]        req_cvt_op,
   input  logic [9:0]        req_opcode,
   input  logic              rsp_ready,
   input  logic [31:0]       rsp_result,
   input  logic [4:0]        rsp_flags,
   output logic              rec_valid,
   output logic [155:0]      rec_data,
   input  logic              rec_ready,
   output logic [CNT_W-1:0]  drop_count,
   output logic              err_overlap,
   output logic              err_orphan,
   output logic              err_badop
);

   localparam int              c_addr_w = $clog2(DEPTH);
   localparam logic [c_addr_w:0] c_full_count = DEPTH[c_addr_w:0];

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_capture;
   logic                w_complete;
   logic                w_set_overlap;
   logic                w_set_orphan;

   logic [31:0]         r_data1;
   logic [31:0]         r_data2;
   logic [31:0]         r_data3;
   logic [2:0]          r_rm;
   logic [1:0]          r_cvt_op;
   logic [9:0]          r_opcode;

   logic [155:0]        r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_addr_w:0]   r_count;
   logic [CNT_W-1:0]    r_drop_count;
   logic                r_err_overlap;
   logic                r_err_orphan;
   logic                r_err_badop;

   logic [155:0]        w_record;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_badop;

   always_ff @(posedge clock) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // A response in the capture cycle is seen in IDLE, so it is an orphan.
   always_comb begin
      w_next_state  = r_state;
      w_capture     = 1'b0;
      w_complete    = 1'b0;
      w_set_overlap = 1'b0;
      w_set_orphan  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_set_orphan = rsp_ready;
            if (req_valid) begin
               w_capture    = 1'b1;
               w_next_state = ST_PEND;
            end
         end
         ST_PEND: begin
            if (rsp_ready) begin
               w_complete = 1'b1;
               if (req_valid) w_capture    = 1'b1;
               else           w_next_state = ST_IDLE;
            end else if (req_valid) begin
               w_set_overlap = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_badop = !$onehot(req_opcode) || req_opcode[7];

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_data1  <= '0;
         r_data2  <= '0;
         r_data3  <= '0;
         r_rm     <= '0;
         r_cvt_op <= '0;
         r_opcode <= '0;
      end else if (w_capture) begin
         r_data1  <= req_data1;
         r_data2  <= req_data2;
         r_data3  <= req_data3;
         r_rm     <= req_rm;
         r_cvt_op <= req_cvt_op;
         r_opcode <= req_opcode;
      end
   end

   assign w_record = {r_data1, r_data2, r_data3, rsp_result, 3'b000, rsp_flags,
                      1'b0, r_rm, 2'b00, r_cvt_op, 2'b00, r_opcode};

   assign w_full  = (r_count == c_full_count);
   assign w_pop   = rec_valid && rec_ready;
   assign w_push  = w_complete && (!w_full || w_pop);
   assign w_drop  = w_complete && w_full && !w_pop;

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= w_record;
   end

   // Pointers are exactly c_addr_w bits wide, so they wrap modulo DEPTH.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_drop_count  <= '0;
         r_err_overlap <= 1'b0;
         r_err_orphan  <= 1'b0;
         r_err_badop   <= 1'b0;
      end else begin
         if (w_drop && (r_drop_count != {CNT_W{1'b1}}))
            r_drop_count <= r_drop_count + 1'b1;
         if (w_set_overlap)        r_err_overlap <= 1'b1;
         if (w_set_orphan)         r_err_orphan  <= 1'b1;
         if (w_capture && w_badop) r_err_badop   <= 1'b1;
      end
   end

   assign rec_valid   = (r_count != '0);
   assign rec_data    = rec_valid ? r_mem[r_rd_ptr] : '0;
   assign drop_count  = r_drop_count;
   assign err_overlap = r_err_overlap;
   assign err_orphan  = r_err_orphan;
   assign err_badop   = r_err_badop;

endmodule
`default_nettype wire

// File: tb/tb_fp_trace_packer.sv
`default_nettype none
// ============================================================================
// tb_fp_trace_packer : directed self-checking bench for fp_trace_packer.
//                      Rev 1.0
// ============================================================================
module tb_fp_trace_packer;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic [31:0]   req_data1, req_data2, req_data3;
   logic [2:0]    req_rm;
   logic [1:0]    req_cvt_op;
   logic [9:0]    req_opcode;
   logic          rsp_ready;
   logic [31:0]   rsp_result;
   logic [4:0]    rsp_flags;
   logic          rec_valid;
   logic [155:0]  rec_data;
   logic          rec_ready;
   logic [15:0]   drop_count;
   logic          err_overlap, err_orphan, err_badop;

   int n_checks = 0;
   int n_fail   = 0;

   fp_trace_packer #(.DEPTH(4), .CNT_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data1  (req_data1),
      .req_data2  (req_data2),
      .req_data3  (req_data3),
      .req_rm     (req_rm),
      .req_cvt_op (req_cvt_op),
      .req_opcode (req_opcode),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rec_valid  (rec_valid),
      .rec_data   (rec_data),
      .rec_ready  (rec_ready),
      .drop_count (drop_count),
      .err_overlap(err_overlap),
      .err_orphan (err_orphan),
      .err_badop  (err_badop)
   );

   always #5 clock = ~clock;

   function automatic logic [155:0] mkrec(input logic [31:0] d1, input logic [31:0] d2,
                                          input logic [31:0] d3, input logic [31:0] res,
                                          input logic [4:0] fl, input logic [2:0] rm,
                                          input logic [1:0] cvt, input logic [9:0] op);
      return {d1, d2, d3, res, 3'b000, fl, 1'b0, rm, 2'b00, cvt, 2'b00, op};
   endfunction

   task automatic check(input string tag, input logic [155:0] obs, input logic [155:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                        input logic [2:0] rm, input logic [1:0] cvt, input logic [9:0] op);
      req_valid  = 1'b1;
      req_data1  = d1;
      req_data2  = d2;
      req_data3  = d3;
      req_rm     = rm;
      req_cvt_op = cvt;
      req_opcode = op;
   endtask

   task automatic respond(input logic [31:0] res, input logic [4:0] fl);
      rsp_ready  = 1'b1;
      rsp_result = res;
      rsp_flags  = fl;
   endtask

   // One complete issue/response pair with the response one cycle after capture.
   task automatic op_pair(input int i);
      issue(32'(i), 32'h0, 32'h0, 3'b000, 2'b00, 10'h002);
      tick();
      req_valid = 1'b0;
      respond(32'h100 + 32'(i), 5'b00000);
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; rec_ready = 1'b0;
      req_data1 = '0; req_data2 = '0; req_data3 = '0;
      req_rm = '0; req_cvt_op = '0; req_opcode = '0;
      rsp_result = '0; rsp_flags = '0;
      tick(); tick();
      check("reset_rec_valid", rec_valid, 0);
      check("reset_rec_data", rec_data, 0);
      check("reset_drop", drop_count, 0);
      check("reset_errs", {err_overlap, err_orphan, err_badop}, 0);
      reset = 1'b1;

      // fadd, response three cycles after issue
      issue(32'h3F800000, 32'h40000000, 32'h00000000, 3'b000, 2'b00, 10'h002);
      tick();
      req_valid = 1'b0;
      tick(); tick();
      check("fadd_not_yet", rec_valid, 0);
      respond(32'h40400000, 5'b00000);
      tick();
      rsp_ready = 1'b0;
      check("fadd_valid", rec_valid, 1);
      check("fadd_rec", rec_data,
            mkrec(32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 5'b0, 3'b000, 2'b00, 10'h002));
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      check("fadd_popped", rec_valid, 0);

      // back-to-back: fdiv issued in the fmul completion cycle
      issue(32'h40000000, 32'h40400000, 32'h0, 3'b001, 2'b00, 10'h008);
      tick();
      respond(32'h40C00000, 5'b00000);
      issue(32'h3F800000, 32'h40400000, 32'h0, 3'b000, 2'b00, 10'h010);
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      check("b2b_fmul", rec_data,
            mkrec(32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 5'b0, 3'b001, 2'b00, 10'h008));
      repeat (9) tick();
      respond(32'h3EAAAAAB, 5'b01000);
      tick();
      rsp_ready = 1'b0;
      check("b2b_head_kept", rec_data,
            mkrec(32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 5'b0, 3'b001, 2'b00, 10'h008));
      rec_ready = 1'b1;
      tick();
      check("b2b_fdiv", rec_data,
            mkrec(32'h3F800000, 32'h40400000, 32'h0, 32'h3EAAAAAB, 5'b01000, 3'b000, 2'b00, 10'h010));
      tick();
      rec_ready = 1'b0;
      check("b2b_empty", rec_valid, 0);
      check("b2b_no_overlap", err_overlap, 0);

      // overflow: six completions into a 4-deep FIFO
      for (int i = 0; i < 6; i++) op_pair(i);
      check("ovf_drop", drop_count, 2);
      check("ovf_valid", rec_valid, 1);
      rec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_drain%0d", i), rec_data,
               mkrec(32'(i), 32'h0, 32'h0, 32'h100 + 32'(i), 5'b0, 3'b000, 2'b00, 10'h002));
         tick();
      end
      rec_ready = 1'b0;
      check("ovf_empty", rec_valid, 0);

      // full FIFO, push and pop in the same cycle
      for (int i = 10; i < 14; i++) op_pair(i);
      check("full_drop_kept", drop_count, 2);
      issue(32'd14, 32'h0, 32'h0, 3'b000, 2'b00, 10'h002);
      tick();
      req_valid = 1'b0;
      respond(32'h100 + 32'd14, 5'b00000);
      rec_ready = 1'b1;
      tick();
      rsp_ready = 1'b0; rec_ready = 1'b0;
      check("pp_drop", drop_count, 2);
      rec_ready = 1'b1;
      for (int i = 11; i < 15; i++) begin
         check($sformatf("pp_drain%0d", i), rec_data,
               mkrec(32'(i), 32'h0, 32'h0, 32'h100 + 32'(i), 5'b0, 3'b000, 2'b00, 10'h002));
         tick();
      end
      rec_ready = 1'b0;
      check("pp_empty", rec_valid, 0);

      // orphan response
      check("orphan_pre", err_orphan, 0);
      respond(32'hDEADBEEF, 5'b11111);
      tick();
      rsp_ready = 1'b0;
      check("orphan_set", err_orphan, 1);
      check("orphan_no_rec", rec_valid, 0);

      // overlapping request is ignored
      issue(32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 3'b010, 2'b00, 10'h004);
      tick();
      issue(32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 3'b100, 2'b01, 10'h008);
      tick();
      req_valid = 1'b0;
      respond(32'h12345678, 5'b00001);
      tick();
      rsp_ready = 1'b0;
      check("overlap_set", err_overlap, 1);
      check("overlap_rec", rec_data,
            mkrec(32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'h12345678, 5'b00001, 3'b010, 2'b00, 10'h004));
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;

      // non-one-hot opcode still captured
      check("badop_pre", err_badop, 0);
      issue(32'h11111111, 32'h22222222, 32'h33333333, 3'b111, 2'b11, 10'h006);
      tick();
      req_valid = 1'b0;
      check("badop_set", err_badop, 1);
      respond(32'h44444444, 5'b10000);
      tick();
      rsp_ready = 1'b0;
      check("badop_rec", rec_data,
            mkrec(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 5'b10000, 3'b111, 2'b11, 10'h006));
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;

      // mid-run reset with two queued records and one pending
      op_pair(20);
      op_pair(21);
      issue(32'd22, 32'h0, 32'h0, 3'b000, 2'b00, 10'h002);
      tick();
      req_valid = 1'b0;
      check("mr_queued", rec_valid, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mr_valid", rec_valid, 0);
      check("mr_data", rec_data, 0);
      check("mr_drop", drop_count, 0);
      check("mr_errs", {err_overlap, err_orphan, err_badop}, 0);
      respond(32'h55555555, 5'b00000);
      tick();
      rsp_ready = 1'b0;
      check("mr_pending_gone", rec_valid, 0);
      check("mr_orphan", err_orphan, 1);
      issue(32'hC0000001, 32'hC0000002, 32'hC0000003, 3'b011, 2'b10, 10'h200);
      tick();
      req_valid = 1'b0;
      respond(32'h66666666, 5'b00100);
      tick();
      rsp_ready = 1'b0;
      check("mr_post_rec", rec_data,
            mkrec(32'hC0000001, 32'hC0000002, 32'hC0000003, 32'h66666666, 5'b00100, 3'b011, 2'b10, 10'h200));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
